// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// chunk-width derivation, configuration check and the result flag bundle.
package pipelined_addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The operand must split into equal, non-empty chunks, one per stage.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_chunk.sv
// One CHUNK-bit ripple-carry slice. Also exposes the carry into its top bit so
// the final slice can derive signed overflow.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // Plain full-adder ripple across the slice.
  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor. Stage k adds chunk k; the operand
// slices still to be consumed travel alongside the partial result, shrinking by
// one chunk per stage, so each stage register holds only what is still needed.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic   adv;
  flags_t flags_q;

  // The whole pipeline moves together unless a finished beat is blocked at the output.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic                v_d;
    logic                c_d;
    logic                co_chunk;
    logic                v_q;
    logic [REM-1:0]      a_cur;
    logic [REM-1:0]      b_cur;
    logic [CHUNK-1:0]    s_chunk;
    logic [LO+CHUNK-1:0] res_d;
    logic [LO+CHUNK-1:0] res_q;

    if (k == 0) begin : src
      // Subtraction is a + ~b + 1: invert b once here and seed the carry.
      assign v_d   = in_valid && in_ready;
      assign c_d   = sub;
      assign a_cur = a;
      assign b_cur = sub ? ~b : b;
      assign res_d = s_chunk;
    end else begin : src
      assign v_d   = stg[k-1].v_q;
      assign c_d   = stg[k-1].fwd.c_q;
      assign a_cur = stg[k-1].fwd.a_q;
      assign b_cur = stg[k-1].fwd.b_q;
      assign res_d = {s_chunk, stg[k-1].res_q};
    end

    // Valid bit and the accumulated low result chunks advance with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= v_d;
        res_q <= res_d;
      end
    end

    if (k == STAGES - 1) begin : last
      logic   c_msb;
      flags_t flags_d;

      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_cur),
        .b     (b_cur),
        .cin   (c_d),
        .sum   (s_chunk),
        .cout  (co_chunk),
        .c_msb (c_msb)
      );

      // Flags come from the complete sum and the top slice's carries.
      always_comb begin
        flags_d      = '0;
        flags_d.cout = co_chunk;
        flags_d.zero = (res_d == '0);
        flags_d.neg  = res_d[WIDTH-1];
        flags_d.ovf  = c_msb ^ co_chunk;
      end

      // Flags register alongside the final sum so the output beat is fully registered.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_q <= '0;
        end else if (adv) begin
          flags_q <= flags_d;
        end
      end
    end else begin : fwd
      logic                 c_msb_unused;
      logic                 c_q;
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;

      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_cur[CHUNK-1:0]),
        .b     (b_cur[CHUNK-1:0]),
        .cin   (c_d),
        .sum   (s_chunk),
        .cout  (co_chunk),
        .c_msb (c_msb_unused)
      );

      // Carry and the not-yet-added operand slices move to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          c_q <= co_chunk;
          a_q <= a_cur[REM-1:CHUNK];
          b_q <= b_cur[REM-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign sum       = stg[STAGES-1].res_q;
  assign cout      = flags_q.cout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 32/4 instance driven through a scoreboard, plus
// 32/1 and 8/8 instances for latency and reset-flush corners.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a, b;
  logic        sub;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, zero, neg, ovf;

  logic        v1, r1, ov1, rdy1, c1, z1, n1, o1;
  logic [31:0] s1;
  logic        v2, r2, ov2, rdy2, c2, z2, n2, o2;
  logic [7:0]  s2;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
    .a(a), .b(b), .sub(sub), .out_valid(ov1), .out_ready(rdy1),
    .sum(s1), .cout(c1), .zero(z1), .neg(n1), .ovf(o1)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ov2), .out_ready(rdy2),
    .sum(s2), .cout(c2), .zero(z2), .neg(n2), .ovf(o2)
  );

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: wide integer add, overflow from operand/result signs.
  function automatic res_t model(input logic [31:0] aa, input logic [31:0] bb,
                                 input logic ss, input int w);
    logic [63:0] mask, bx, full;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    bx     = ss ? ((~{32'd0, bb}) & mask) : ({32'd0, bb} & mask);
    full   = ({32'd0, aa} & mask) + bx + {63'd0, ss};
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.zero = ((full & mask) == 64'd0);
    r.neg  = full[w-1];
    r.ovf  = (aa[w-1] == bx[w-1]) && (full[w-1] != aa[w-1]);
    return r;
  endfunction

  // Scoreboard side: compare each emitted beat, and check a stalled beat holds.
  res_t held;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    cur = {sum, cout, zero, neg, ovf};
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_hold_valid", out_valid, 1'b1);
        chk("stall_hold_data", cur, held);
      end
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", cur, e);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = cur;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic ss,
                      input res_t e);
    int g = 0;
    bit ok = 1'b1;
    a = aa; b = bb; sub = ss; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      g++;
      if (g > 200) begin
        chk("accept_timeout", 0, 1);
        ok = 1'b0;
        break;
      end
    end
    if (ok) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic lat0(input logic [31:0] aa, input logic [31:0] bb, input logic ss);
    int n = 0;
    send(aa, bb, ss, model(aa, bb, ss, 32));
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency_s4", n, 4);
    @(posedge clk); #1;
  endtask

  // Single beat into the 32/1 (which=1) or 8/8 (which=2) instance.
  task automatic lat_other(input int which, input logic [31:0] aa, input logic [31:0] bb,
                           input logic ss, input int exp_lat);
    res_t e, g;
    int   n = 0;
    e = model(aa, bb, ss, (which == 1) ? 32 : 8);
    a = aa; b = bb; sub = ss;
    if (which == 1) v1 = 1'b1; else v2 = 1'b1;
    @(negedge clk);
    chk("in_ready_other", (which == 1) ? r1 : r2, 1'b1);
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((which == 1) ? ov1 : ov2) break;
    end
    chk((which == 1) ? "latency_s1" : "latency_w8s8", n, exp_lat);
    g = (which == 1) ? {s1, c1, z1, n1, o1} : {24'd0, s2, c2, z2, n2, o2};
    chk((which == 1) ? "result_s1" : "result_w8s8", g, e);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  bit   rnd_done;

  initial begin
    tbl[0] = '{32'h0000_00FF, 32'h1, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{32'hFFFF_FFFF, 32'h1, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{32'h0000_0005, 32'h7, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[3] = '{32'h0000_0007, 32'h7, 1'b1, '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{32'h7FFF_FFFF, 32'h1, 1'b0, '{32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[5] = '{32'h8000_0000, 32'h1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{32'h0000_0000, 32'h0, 1'b1, '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{32'h0000_0000, 32'h1, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[8] = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, '{32'h0002_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0;
    v1 = 1'b0; v2 = 1'b0; rdy1 = 1'b1; rdy2 = 1'b1;

    repeat (2) @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_outputs", {sum, cout, zero, neg, ovf}, 36'd0);
    chk("reset_out_valid_s1", ov1, 1'b0);
    chk("reset_out_valid_w8s8", ov2, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    lat0(32'h0000_1234, 32'h0000_0001, 1'b0);

    // Table vectors streamed back to back.
    for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].exp);
    drain();

    // Eight beats with a three-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] xa, xb;
          xa = 32'h1000_0000 * i + 32'h0F0F_00FF;
          xb = 32'h0100_0101 * (i + 1);
          send(xa, xb, i[0], model(xa, xb, i[0], 32));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_out_valid", out_valid, 1'b1);
          chk("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands, random idle gaps and random back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] ra, rb;
          logic        rs;
          ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
          if (i % 8 == 3) rb = ra;
          send(ra, rb, rs, model(ra, rb, rs, 32));
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight in every instance.
    rdy1 = 1'b0; v1 = 1'b1; v2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] xa;
      xa = 32'h0000_0040 + i;
      send(xa, 32'h3, 1'b0, model(xa, 32'h3, 1'b0, 32));
    end
    v1 = 1'b0; v2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flush_out_valid", out_valid, 1'b0);
    chk("rst_flush_out_valid_s1", ov1, 1'b0);
    chk("rst_flush_out_valid_w8s8", ov2, 1'b0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1; rdy1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {out_valid, ov1, ov2}, 3'b000);
    end
    @(posedge clk); #1;

    lat0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    lat_other(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1);
    lat_other(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1);
    lat_other(2, 32'h0000_007F, 32'h0000_0001, 1'b0, 8);
    lat_other(2, 32'h0000_0005, 32'h0000_0007, 1'b1, 8);
    lat_other(2, 32'h0000_00FF, 32'h0000_0001, 1'b0, 8);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
